// File: rtl/i2c_bmc_reg_map_if.sv
// Byte-level bus between the BMC I2C slave engine and its register bank.
interface i2c_bmc_reg_map_if;
   logic        i_i2c_start;
   logic        i_r_w;
   logic        i_data_vld_pos;
   logic [15:0] i_command;
   logic [7:0]  i_wdata;
   logic [7:0]  o_rdata;

   modport master (
      output i_i2c_start, i_r_w, i_data_vld_pos, i_command, i_wdata,
      input  o_rdata
   );

   modport slave (
      input  i_i2c_start, i_r_w, i_data_vld_pos, i_command, i_wdata,
      output o_rdata
   );
endinterface

// File: rtl/i2c_bmc_reg_map.sv
// Register bank behind the BMC I2C slave: snapshotted status bytes, key-protected control
// bytes, a W1C event latch and a saturating bad-access counter.
module i2c_bmc_reg_map #(
   parameter logic [7:0]          BASE_HI    = 8'h00,
   parameter int                  NUM_RO     = 16,
   parameter int                  NUM_RW     = 16,
   parameter logic [NUM_RW*8-1:0] CTRL_RST   = '0,
   parameter logic [7:0]          UNLOCK_KEY = 8'h5A,
   parameter logic [15:0]         UNLOCK_MS  = 16'd1000,
   parameter int                  WR_DLY     = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_1ms_tick,
   i2c_bmc_reg_map_if.slave       bus,
   input  logic [NUM_RO*8-1:0]    i_status,
   input  logic [7:0]             i_event,
   output logic [NUM_RW*8-1:0]    o_ctrl,
   output logic                   o_wr_pulse,
   output logic [7:0]             o_wr_offset
);
   localparam logic [7:0] OFF_RW   = 8'h40;
   localparam logic [7:0] OFF_BAD  = 8'h7D;
   localparam logic [7:0] OFF_EVT  = 8'h7E;
   localparam logic [7:0] OFF_LOCK = 8'h7F;
   localparam logic [8:0] RO_END   = 9'(NUM_RO);
   localparam logic [8:0] RW_END   = 9'(64 + NUM_RW);

   typedef enum logic {ST_LOCKED, ST_UNLOCKED} lock_e;

   lock_e              state_q, state_d;
   logic [15:0]        tmo_q, tmo_d;
   logic               start_q;
   logic [NUM_RO*8-1:0] snap_q;
   logic [7:0]         evt_q, bad_q;
   logic [WR_DLY-1:0]  wv_q;
   logic [7:0]         wd_q [WR_DLY];

   logic [7:0] off, wr_data, rd_byte;
   logic       cmd_none, cmd_hit, in_ro, in_rw, unlocked;
   logic       wr_any, wr_hit, wr_lock, wr_ctrl, wr_evt, wr_bclr, wr_bad;

   assign off      = bus.i_command[7:0];
   assign cmd_none = bus.i_command == 16'hFFFF;
   assign cmd_hit  = !cmd_none && (bus.i_command[15:8] == BASE_HI);
   assign in_ro    = {1'b0, off} < RO_END;
   assign in_rw    = (off >= OFF_RW) && ({1'b0, off} < RW_END);
   assign unlocked = state_q == ST_UNLOCKED;

   // The delayed strobe is decoded against the pointer present now, not at strobe time.
   assign wr_data = wd_q[WR_DLY-1];
   assign wr_any  = wv_q[WR_DLY-1] && !cmd_none;
   assign wr_hit  = wr_any && cmd_hit;
   assign wr_lock = wr_hit && (off == OFF_LOCK);
   assign wr_ctrl = wr_hit && in_rw && unlocked;
   assign wr_evt  = wr_hit && (off == OFF_EVT);
   assign wr_bclr = wr_hit && (off == OFF_BAD);
   assign wr_bad  = wr_any && !(cmd_hit && ((in_rw && unlocked) || (off == OFF_LOCK) ||
                                            (off == OFF_EVT) || (off == OFF_BAD)));

   always_comb begin
      // NOTE: default assigned first so every path drives rd_byte and no latch is inferred.
      rd_byte = 8'hFF;
      if (cmd_hit) begin
         if (in_ro) begin
            for (int i = 0; i < NUM_RO; i++)
               if (off == 8'(i)) rd_byte = snap_q[8*i +: 8];
         end
         if (in_rw) begin
            for (int i = 0; i < NUM_RW; i++)
               if (off == 8'(64 + i)) rd_byte = o_ctrl[8*i +: 8];
         end
         case (off)
            OFF_BAD:  rd_byte = bad_q;
            OFF_EVT:  rd_byte = evt_q;
            OFF_LOCK: rd_byte = {7'd0, unlocked};
            default:  ;
         endcase
      end
   end

   // Lock state: accepted writes restart the timeout and swallow a coincident tick.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_UNLOCKED: begin
            if ((UNLOCK_MS != 16'd0) && i_1ms_tick) begin
               if (16'(tmo_q + 16'd1) == UNLOCK_MS) begin
                  state_d = ST_LOCKED;
                  tmo_d   = '0;
               end else begin
                  tmo_d = 16'(tmo_q + 16'd1);
               end
            end
            if (wr_ctrl) begin
               state_d = ST_UNLOCKED;
               tmo_d   = '0;
            end
         end
         default: ;
      endcase
      if (wr_lock) begin
         state_d = (wr_data == UNLOCK_KEY) ? ST_UNLOCKED : ST_LOCKED;
         tmo_d   = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_LOCKED;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wv_q <= '0;
         // NOTE: the data stages are a small register array, cleared so reset leaves no stale byte behind.
         for (int i = 0; i < WR_DLY; i++) wd_q[i] <= '0;
      end else begin
         wv_q[0] <= bus.i_data_vld_pos && !bus.i_r_w;
         wd_q[0] <= bus.i_wdata;
         for (int i = 1; i < WR_DLY; i++) begin
            wv_q[i] <= wv_q[i-1];
            wd_q[i] <= wd_q[i-1];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_rst) begin
         start_q     <= 1'b0;
         snap_q      <= '0;
         evt_q       <= '0;
         bad_q       <= '0;
         o_ctrl      <= CTRL_RST;
         bus.o_rdata <= '0;
         o_wr_pulse  <= 1'b0;
         o_wr_offset <= '0;
      end else begin
         start_q     <= bus.i_i2c_start;
         bus.o_rdata <= rd_byte;
         o_wr_pulse  <= wr_ctrl;
         if (bus.i_i2c_start && !start_q) snap_q <= i_status;

         if (wr_ctrl) begin
            o_wr_offset <= off;
            for (int i = 0; i < NUM_RW; i++)
               if (off == 8'(64 + i)) o_ctrl[8*i +: 8] <= wr_data;
         end

         if (wr_evt) evt_q <= (evt_q & ~wr_data) | i_event;
         else        evt_q <= evt_q | i_event;

         if (wr_bclr)                        bad_q <= '0;
         else if (wr_bad && bad_q != 8'hFF)  bad_q <= bad_q + 8'd1;
      end
   end
endmodule

// File: tb/tb_i2c_bmc_reg_map.sv
// Self-checking bench for i2c_bmc_reg_map: constant vector table, directed corner sequences
// and randomized traffic compared every cycle against a transaction-level model.
module tb_i2c_bmc_reg_map;
   localparam int          NUM_RO = 16;
   localparam int          NUM_RW = 16;
   localparam int          WR_DLY = 2;
   localparam logic [7:0]  KEY    = 8'h5A;
   localparam logic [15:0] TMO    = 16'd1000;

   logic                clk = 1'b0;
   logic                rst, tick;
   logic [NUM_RO*8-1:0] status;
   logic [7:0]          evt;
   logic [NUM_RW*8-1:0] ctrl;
   logic                wr_pulse;
   logic [7:0]          wr_offset;

   i2c_bmc_reg_map_if bus ();

   i2c_bmc_reg_map #(
      .BASE_HI(8'h00), .NUM_RO(NUM_RO), .NUM_RW(NUM_RW), .CTRL_RST('0),
      .UNLOCK_KEY(KEY), .UNLOCK_MS(TMO), .WR_DLY(WR_DLY)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_1ms_tick(tick), .bus(bus),
      .i_status(status), .i_event(evt), .o_ctrl(ctrl),
      .o_wr_pulse(wr_pulse), .o_wr_offset(wr_offset)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte arrays plus a queue of writes waiting out the alignment delay.
   typedef struct { logic [7:0] data; int due; } pend_t;
   logic [7:0] m_snap [NUM_RO];
   logic [7:0] m_ctrl [NUM_RW];
   logic [7:0] m_ev, m_bad, m_rdata, m_off;
   bit         m_unl, m_pulse, m_prev_start;
   int         m_cnt, cyc = 0;
   pend_t      m_q[$];

   function automatic logic [7:0] m_read(input logic [15:0] c);
      int o = int'(c[7:0]);
      if (c == 16'hFFFF || c[15:8] != 8'h00) return 8'hFF;
      if (o < NUM_RO) return m_snap[o];
      if (o >= 64 && o < 64 + NUM_RW) return m_ctrl[o-64];
      if (o == 'h7D) return m_bad;
      if (o == 'h7E) return m_ev;
      if (o == 'h7F) return {7'd0, m_unl};
      return 8'hFF;
   endfunction

   function automatic logic [NUM_RW*8-1:0] m_ctrl_vec();
      logic [NUM_RW*8-1:0] v;
      for (int i = 0; i < NUM_RW; i++) v[8*i +: 8] = m_ctrl[i];
      return v;
   endfunction

   task automatic model_edge();
      logic [15:0] c = bus.i_command;
      int  o = int'(c[7:0]);
      bit  accepted = 0, unl_pre = m_unl, w1c = 0, bad = 0;
      logic [7:0] d;
      if (rst) begin
         foreach (m_snap[i]) m_snap[i] = 8'h00;
         foreach (m_ctrl[i]) m_ctrl[i] = 8'h00;
         m_ev = 0; m_bad = 0; m_unl = 0; m_cnt = 0; m_q.delete();
         m_rdata = 0; m_pulse = 0; m_off = 0; m_prev_start = 0;
         cyc++;
         return;
      end
      m_rdata = m_read(c);
      m_pulse = 0;
      while (m_q.size() > 0 && m_q[0].due == cyc) begin
         d = m_q.pop_front().data;
         if (c == 16'hFFFF) continue;
         if (c[15:8] != 8'h00) bad = 1;
         else if (o == 'h7F) begin accepted = 1; m_unl = (d == KEY); m_cnt = 0; end
         else if (o >= 64 && o < 64 + NUM_RW) begin
            if (m_unl) begin
               m_ctrl[o-64] = d; m_pulse = 1; m_off = 8'(o); m_cnt = 0; accepted = 1;
            end else bad = 1;
         end
         else if (o == 'h7E) begin m_ev = m_ev & ~d; w1c = 1; end
         else if (o == 'h7D) m_bad = 0;
         else bad = 1;
      end
      if (bad && m_bad != 8'hFF) m_bad++;
      if (!accepted && unl_pre && tick && TMO != 0) begin
         m_cnt++;
         if (m_cnt == int'(TMO)) begin m_unl = 0; m_cnt = 0; end
      end
      m_ev = m_ev | evt;
      if (bus.i_i2c_start && !m_prev_start)
         for (int i = 0; i < NUM_RO; i++) m_snap[i] = status[8*i +: 8];
      m_prev_start = bus.i_i2c_start;
      if (bus.i_data_vld_pos && !bus.i_r_w) m_q.push_back('{bus.i_wdata, cyc + WR_DLY});
      cyc++;
      if (w1c) ; // set-wins already applied by the OR above
   endtask

   task automatic step();
      model_edge();
      @(posedge clk); #1;
      check("rdata", bus.o_rdata, m_rdata);
      check("ctrl", ctrl, m_ctrl_vec());
      check("wr_pulse", wr_pulse, m_pulse);
      check("wr_offset", wr_offset, m_off);
   endtask

   task automatic read_reg(input logic [15:0] c, output logic [7:0] v);
      bus.i_command = c; bus.i_data_vld_pos = 0;
      step();
      v = bus.o_rdata;
   endtask

   task automatic write_reg(input logic [15:0] c, input logic [7:0] d);
      bus.i_command = c; bus.i_wdata = d; bus.i_r_w = 0; bus.i_data_vld_pos = 1;
      step();
      bus.i_data_vld_pos = 0;
      repeat (WR_DLY) step();
   endtask

   typedef struct { bit wr; logic [15:0] cmd; logic [7:0] data; logic [7:0] exp; } vec_t;
   vec_t tbl[$];

   initial begin
      logic [7:0] v;
      int lat;
      rst = 1; tick = 0; status = '0; evt = 0;
      bus.i_i2c_start = 0; bus.i_r_w = 0; bus.i_data_vld_pos = 0;
      bus.i_command = 16'hFFFF; bus.i_wdata = 0;
      @(posedge clk); #1;

      // T1 reset
      step(); step();
      check("reset_rdata", bus.o_rdata, 8'h00);
      check("reset_ctrl", ctrl, '0);
      rst = 0;

      tbl = '{
         '{0, 16'h0000, 8'h00, 8'h00}, '{0, 16'h0040, 8'h00, 8'h00},
         '{0, 16'h007F, 8'h00, 8'h00}, '{0, 16'h007D, 8'h00, 8'h00},
         '{0, 16'h007E, 8'h00, 8'h00}, '{0, 16'h0120, 8'h00, 8'hFF},
         '{0, 16'hFFFF, 8'h00, 8'hFF}, '{0, 16'h0010, 8'h00, 8'hFF},
         '{0, 16'h0050, 8'h00, 8'hFF}, '{0, 16'h0080, 8'h00, 8'hFF},
         '{1, 16'h0040, 8'hA5, 8'h00}, '{0, 16'h007D, 8'h00, 8'h01},
         '{0, 16'h0040, 8'h00, 8'h00}, '{1, 16'h007F, 8'h5A, 8'h00},
         '{0, 16'h007F, 8'h00, 8'h01}, '{1, 16'h0040, 8'hA5, 8'h00},
         '{0, 16'h0040, 8'h00, 8'hA5}, '{1, 16'h004F, 8'h3C, 8'h00},
         '{0, 16'h004F, 8'h00, 8'h3C}, '{1, 16'h0005, 8'h77, 8'h00},
         '{0, 16'h007D, 8'h00, 8'h02}, '{1, 16'h0140, 8'h11, 8'h00},
         '{0, 16'h007D, 8'h00, 8'h03}, '{1, 16'hFFFF, 8'h11, 8'h00},
         '{0, 16'h007D, 8'h00, 8'h03}, '{1, 16'h007D, 8'h00, 8'h00},
         '{0, 16'h007D, 8'h00, 8'h00}, '{1, 16'h007F, 8'h00, 8'h00},
         '{0, 16'h007F, 8'h00, 8'h00}
      };
      foreach (tbl[i]) begin
         if (tbl[i].wr) write_reg(tbl[i].cmd, tbl[i].data);
         else begin
            read_reg(tbl[i].cmd, v);
            check($sformatf("vec%0d_rd_%h", i, tbl[i].cmd), v, tbl[i].exp);
         end
      end

      // T3 write pulse latency and offset
      write_reg(16'h007F, KEY);
      bus.i_command = 16'h0042; bus.i_wdata = 8'hC3; bus.i_data_vld_pos = 1;
      step();
      bus.i_data_vld_pos = 0;
      lat = 1;
      while (!wr_pulse && lat < 10) begin step(); lat++; end
      check("pulse_latency", lat, WR_DLY + 1);
      check("pulse_offset", wr_offset, 8'h42);
      check("pulse_ctrl_byte2", ctrl[23:16], 8'hC3);
      step();
      check("pulse_one_cycle", wr_pulse, 1'b0);

      // T4 snapshot atomicity
      status[7:0] = 8'h11; bus.i_i2c_start = 1; step();
      status[7:0] = 8'h22; bus.i_i2c_start = 0; step();
      read_reg(16'h0000, v); check("snap_first", v, 8'h11);
      bus.i_i2c_start = 1; step(); bus.i_i2c_start = 0; step();
      read_reg(16'h0000, v); check("snap_second", v, 8'h22);

      // T5 event latch with set-wins W1C
      evt = 8'h08; step(); evt = 0; step();
      read_reg(16'h007E, v); check("evt_set", v, 8'h08);
      evt = 8'h08; write_reg(16'h007E, 8'h08);
      read_reg(16'h007E, v); check("evt_set_wins", v, 8'h08);
      evt = 0; write_reg(16'h007E, 8'h08);
      read_reg(16'h007E, v); check("evt_cleared", v, 8'h00);

      // T6 relock timeout boundary (still unlocked from T3)
      write_reg(16'h007F, KEY);
      tick = 1; repeat (int'(TMO) - 1) step(); tick = 0;
      read_reg(16'h007F, v); check("relock_999", v, 8'h01);
      tick = 1; step(); tick = 0;
      read_reg(16'h007F, v); check("relock_1000", v, 8'h00);

      // Tick coinciding with an accepted control write is lost
      write_reg(16'h007F, KEY);
      tick = 1; repeat (int'(TMO) - 1) step(); tick = 0;
      bus.i_command = 16'h0041; bus.i_wdata = 8'h66; bus.i_data_vld_pos = 1; step();
      bus.i_data_vld_pos = 0; repeat (WR_DLY - 1) step();
      tick = 1; step(); tick = 0;
      read_reg(16'h007F, v); check("tick_lost", v, 8'h01);
      read_reg(16'h0041, v); check("tick_lost_wr", v, 8'h66);
      tick = 1; repeat (int'(TMO) - 1) step(); tick = 0;
      read_reg(16'h007F, v); check("restart_999", v, 8'h01);
      tick = 1; step(); tick = 0;
      read_reg(16'h007F, v); check("restart_1000", v, 8'h00);

      // Bad counter saturation and clear
      bus.i_command = 16'h0003; bus.i_wdata = 8'h00; bus.i_data_vld_pos = 1;
      repeat (300) step();
      bus.i_data_vld_pos = 0; repeat (WR_DLY) step();
      read_reg(16'h007D, v); check("bad_saturate", v, 8'hFF);
      write_reg(16'h007D, 8'h12);
      read_reg(16'h007D, v); check("bad_clear", v, 8'h00);

      // Reset mid-transaction discards the pending write
      write_reg(16'h007F, KEY);
      bus.i_command = 16'h0043; bus.i_wdata = 8'h99; bus.i_data_vld_pos = 1; step();
      bus.i_data_vld_pos = 0; rst = 1; step(); rst = 0;
      repeat (WR_DLY + 1) step();
      check("rst_discard", ctrl[31:24], 8'h00);
      read_reg(16'h007F, v); check("rst_relocked", v, 8'h00);

      // Randomized traffic against the model
      for (int n = 0; n < 5000; n++) begin
         rst = ($urandom_range(0, 999) == 0);
         case ($urandom_range(0, 9))
            0:       bus.i_command = {8'h00, 8'($urandom_range(0, 15))};
            1, 8, 9: bus.i_command = {8'h00, 8'(64 + $urandom_range(0, 15))};
            2:       bus.i_command = 16'h007F;
            3:       bus.i_command = 16'h007E;
            4:       bus.i_command = 16'h007D;
            5:       bus.i_command = 16'hFFFF;
            6:       bus.i_command = {8'($urandom_range(1, 255)), 8'($urandom)};
            default: bus.i_command = {8'h00, 8'($urandom_range(16, 255))};
         endcase
         bus.i_wdata = (bus.i_command == 16'h007F && $urandom_range(0, 1) == 1) ? KEY : 8'($urandom);
         bus.i_data_vld_pos = ($urandom_range(0, 2) == 0);
         bus.i_r_w = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) bus.i_i2c_start = ~bus.i_i2c_start;
         if ($urandom_range(0, 7) == 0) status = {$urandom, $urandom, $urandom, $urandom};
         evt  = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         tick = ($urandom_range(0, 1) == 1);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
